// File: rtl/intr_ctrl_pkg.sv
// Shared register map and ID sizing for the interrupt controller.
// ID 0 means "no source"; source n sits on bit n-1.
package intr_ctrl_pkg;
  localparam int MAX_SRC = 31;
  localparam int ID_W    = 5;

  typedef enum logic [2:0] {
    REG_PENDING   = 3'd0,
    REG_ENABLE    = 3'd1,
    REG_TRIGGER   = 3'd2,
    REG_CLAIM     = 3'd3,
    REG_INSERVICE = 3'd4,
    REG_CTRL      = 3'd5,
    REG_RAW       = 3'd6,
    REG_RSVD      = 3'd7
  } reg_addr_e;
endpackage

// File: rtl/intr_gateway.sv
// Per-source gateway: edge/level detect, pending and in-service state.
// Pending/in-service update one cycle after their cause; no backpressure.
module intr_gateway
  import intr_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_nreset,
  input  logic i_src,
  input  logic i_edge_mode,
  input  logic i_claim,
  input  logic i_complete,
  input  logic i_w1c,
  output logic o_pending,
  output logic o_inservice
);
  logic r_prev;
  logic r_pending;
  logic r_inservice;
  logic w_event;
  logic w_set;

  assign w_event = i_edge_mode ? (i_src & ~r_prev) : i_src;
  // While in service every new event is dropped, not deferred.
  assign w_set   = w_event & ~r_inservice;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_prev      <= 1'b0;
      r_pending   <= 1'b0;
      r_inservice <= 1'b0;
    end else begin
      r_prev <= i_src;
      if (i_claim)
        r_pending <= 1'b0;
      else if (w_set)
        r_pending <= 1'b1;
      else if (!i_edge_mode && !r_inservice)
        r_pending <= 1'b0;
      else if (i_w1c)
        r_pending <= 1'b0;

      if (i_claim)
        r_inservice <= 1'b1;
      else if (i_complete)
        r_inservice <= 1'b0;
    end
  end

  assign o_pending   = r_pending;
  assign o_inservice = r_inservice;
endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: register file, lowest-ID claim encoder and irq output.
// Read data and rvalid one cycle after an accepted read; reads accepted on alternate cycles only.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int NUMSRC = 8
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cs,
  input  logic [2:0]        addr,
  input  logic              wr,
  input  logic [31:0]       wdata,
  input  logic              rd,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic [NUMSRC-1:0] src_irq,
  output logic              irq
);
  logic [NUMSRC-1:0] r_enable;
  logic [NUMSRC-1:0] r_trigger;
  logic              r_ctrl;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              r_irq;

  logic [NUMSRC-1:0] w_pending;
  logic [NUMSRC-1:0] w_inservice;
  logic [NUMSRC-1:0] w_pe;
  logic [NUMSRC-1:0] w_claim_vec;
  logic [NUMSRC-1:0] w_claim_go;
  logic [NUMSRC-1:0] w_complete;
  logic [NUMSRC-1:0] w_w1c;
  logic [ID_W-1:0]   w_claim_id;
  logic [31:0]       w_rdata;
  logic              w_rd_acc;
  logic              w_wr;
  logic              w_claim_rd;
  logic              w_unused;

  assign w_rd_acc   = cs & rd & ~r_rvalid;
  assign w_wr       = cs & wr;
  assign w_claim_rd = w_rd_acc & (addr == REG_CLAIM);
  assign w_pe       = w_pending & r_enable;
  assign w_w1c      = (w_wr && addr == REG_PENDING) ? wdata[NUMSRC-1:0] : '0;
  assign w_claim_go = w_claim_rd ? w_claim_vec : '0;
  assign w_unused   = ^wdata;

  // Lowest ID wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_claim_id  = '0;
    w_claim_vec = '0;
    w_complete  = '0;
    for (int i = NUMSRC - 1; i >= 0; i--) begin
      if (w_pe[i]) w_claim_id = ID_W'(i + 1);
    end
    for (int i = 0; i < NUMSRC; i++) begin
      w_claim_vec[i] = (w_claim_id == ID_W'(i + 1));
      w_complete[i]  = w_wr && (addr == REG_CLAIM) && (wdata[ID_W-1:0] == ID_W'(i + 1));
    end
  end

  always_comb begin
    w_rdata = '0;
    case (addr)
      REG_PENDING:   w_rdata[NUMSRC-1:0] = w_pending;
      REG_ENABLE:    w_rdata[NUMSRC-1:0] = r_enable;
      REG_TRIGGER:   w_rdata[NUMSRC-1:0] = r_trigger;
      REG_CLAIM:     w_rdata[ID_W-1:0]   = w_claim_id;
      REG_INSERVICE: w_rdata[NUMSRC-1:0] = w_inservice;
      REG_CTRL:      w_rdata[0]          = r_ctrl;
      REG_RAW:       w_rdata[NUMSRC-1:0] = src_irq;
      default:       w_rdata             = '0;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUMSRC; g++) begin : g_gw
      intr_gateway u_gw (
        .i_clk       (clk),
        .i_nreset    (nreset),
        .i_src       (src_irq[g]),
        .i_edge_mode (r_trigger[g]),
        .i_claim     (w_claim_go[g]),
        .i_complete  (w_complete[g]),
        .i_w1c       (w_w1c[g]),
        .o_pending   (w_pending[g]),
        .o_inservice (w_inservice[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_enable  <= '0;
      r_trigger <= '0;
      r_ctrl    <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_rvalid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= w_rdata;
      if (w_wr && addr == REG_ENABLE)  r_enable  <= wdata[NUMSRC-1:0];
      if (w_wr && addr == REG_TRIGGER) r_trigger <= wdata[NUMSRC-1:0];
      if (w_wr && addr == REG_CTRL)    r_ctrl    <= wdata[0];
      r_irq <= r_ctrl & |w_pe;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign irq    = r_irq;
endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: reads push expected data, a negedge monitor pops on rvalid.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic        clk;
  logic        nreset;
  logic        cs;
  logic [2:0]  addr;
  logic        wr;
  logic [31:0] wdata;
  logic        rd;
  logic [31:0] rdata;
  logic        rvalid;
  logic [7:0]  src_irq;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] m_exp;
  string       m_tag;

  intr_ctrl #(.NUMSRC(8)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .cs      (cs),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .rd      (rd),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .src_irq (src_irq),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rvalid: got rdata=0x%08h want=no read outstanding", rdata);
      end else begin
        m_exp = exp_q.pop_front();
        m_tag = tag_q.pop_front();
        check(m_tag, rdata, m_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
    cs = 1'b1; rd = 1'b1; addr = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    cs = 1'b0; rd = 1'b0;
    tick();
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  task automatic pulse(input int b);
    src_irq[b] = 1'b1;
    tick();
    src_irq[b] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nreset = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; src_irq = '0;
    repeat (3) tick();
    nreset = 1'b1;
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_rvalid", {31'd0, rvalid}, 32'd0);
    for (int a = 0; a < 8; a++) do_read(3'(a), 32'd0, $sformatf("reset_read_a%0d", a));
    check("reset_irq_after_reads", {31'd0, irq}, 32'd0);

    // Upper bits ignored; held rd only accepted every other cycle
    do_write(REG_ENABLE, 32'hFFFF_FFA5);
    cs = 1'b1; rd = 1'b1; addr = REG_ENABLE;
    exp_q.push_back(32'h0000_00A5);
    tag_q.push_back("enable_upper_bits");
    tick();
    tick();
    check("b2b_rvalid_low", {31'd0, rvalid}, 32'd0);
    cs = 1'b0; rd = 1'b0;
    tick();

    // Edge source 1
    do_write(REG_ENABLE, 32'h1);
    do_write(REG_CTRL, 32'hFFFF_FFFF);
    do_write(REG_TRIGGER, 32'h1);
    do_read(REG_CTRL, 32'h1, "ctrl_readback");
    pulse(0);
    check("edge_irq_1cyc", {31'd0, irq}, 32'd0);
    tick();
    check("edge_irq_2cyc", {31'd0, irq}, 32'd1);
    do_read(REG_PENDING, 32'h1, "edge_pending");
    do_read(REG_CLAIM, 32'd1, "edge_claim");
    check("edge_irq_fall", {31'd0, irq}, 32'd0);
    do_read(REG_INSERVICE, 32'h1, "edge_inservice");
    do_write(REG_CLAIM, 32'd1);
    do_read(REG_INSERVICE, 32'h0, "edge_complete");
    do_read(REG_PENDING, 32'h0, "edge_pending_clear");

    // Level sources 3 and 5
    do_write(REG_TRIGGER, 32'h0);
    do_write(REG_ENABLE, 32'h14);
    src_irq = 8'h14;
    tick(); tick();
    do_read(REG_PENDING, 32'h14, "lvl_pending");
    do_read(REG_RAW, 32'h14, "lvl_raw");
    do_read(REG_CLAIM, 32'd3, "lvl_claim3");
    do_read(REG_CLAIM, 32'd5, "lvl_claim5");
    do_read(REG_PENDING, 32'h0, "lvl_pending_blocked");
    do_read(REG_INSERVICE, 32'h14, "lvl_inservice");
    check("lvl_irq_low", {31'd0, irq}, 32'd0);
    do_write(REG_CLAIM, 32'd3);
    do_read(REG_PENDING, 32'h0, "lvl_repend_not_yet");
    do_read(REG_PENDING, 32'h4, "lvl_repend");
    check("lvl_irq_repend", {31'd0, irq}, 32'd1);
    do_write(REG_CLAIM, 32'd0);
    do_write(REG_CLAIM, 32'd9);
    do_read(REG_INSERVICE, 32'h10, "complete_bad_id");
    src_irq = 8'h00;
    do_write(REG_CLAIM, 32'd5);
    tick(); tick();
    do_read(REG_PENDING, 32'h0, "lvl_follow_low");
    do_read(REG_INSERVICE, 32'h0, "lvl_inservice_clear");

    // Second edge while in service is dropped
    do_write(REG_TRIGGER, 32'h1);
    do_write(REG_ENABLE, 32'h1);
    pulse(0);
    do_read(REG_CLAIM, 32'd1, "drop_claim");
    pulse(0);
    tick();
    do_write(REG_CLAIM, 32'd1);
    tick(); tick();
    do_read(REG_PENDING, 32'h0, "drop_pending");
    check("drop_irq", {31'd0, irq}, 32'd0);

    // Set beats same-cycle W1C
    pulse(0);
    tick();
    src_irq[0] = 1'b1;
    cs = 1'b1; wr = 1'b1; addr = REG_PENDING; wdata = 32'h1;
    tick();
    cs = 1'b0; wr = 1'b0; wdata = '0; src_irq[0] = 1'b0;
    do_read(REG_PENDING, 32'h1, "w1c_vs_set");
    do_write(REG_PENDING, 32'h1);
    do_read(REG_PENDING, 32'h0, "w1c_alone");

    // Reset right after an accepted claim
    pulse(0);
    tick();
    cs = 1'b1; rd = 1'b1; addr = REG_CLAIM;
    exp_q.push_back(32'd1);
    tag_q.push_back("rst_claim_data");
    tick();
    cs = 1'b0; rd = 1'b0; nreset = 1'b0;
    tick();
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    nreset = 1'b1;
    do_read(REG_INSERVICE, 32'h0, "rst_inservice");
    do_read(REG_ENABLE, 32'h0, "rst_enable");
    check("rst_irq_after", {31'd0, irq}, 32'd0);

    repeat (4) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
